// File: rtl/ds1302_rtc_ctrl.sv
// Sequencer for a DS1302 single-byte read/write engine: clears write-protect,
// polls the seven timekeeping registers into a coherent snapshot, and performs host time sets.
module ds1302_rtc_ctrl #(
  parameter int unsigned sys_clk_freq   = 50_000_000,
  parameter int unsigned poll_ms        = 100,
  parameter int unsigned timeout_cycles = 20_000
) (
  input  logic       sclk,
  input  logic       rst,
  input  logic       set_trigger,
  input  logic [7:0] set_sec,
  input  logic [7:0] set_min,
  input  logic [7:0] set_hour,
  input  logic [7:0] set_date,
  input  logic [7:0] set_month,
  input  logic [7:0] set_week,
  input  logic [7:0] set_year,
  output logic [7:0] sec,
  output logic [7:0] min,
  output logic [7:0] hour,
  output logic [7:0] date,
  output logic [7:0] month,
  output logic [7:0] week,
  output logic [7:0] year,
  output logic       time_valid,
  output logic       set_done,
  output logic       err,
  output logic       busy,
  output logic [7:0] rw_addr,
  output logic [7:0] rw_wdata,
  output logic       rw_write_trigger,
  output logic       rw_read_trigger,
  input  logic [7:0] rw_read_byte,
  input  logic       rw_write_done,
  input  logic       rw_read_done
);

  localparam int unsigned poll_cycles = sys_clk_freq / 1000 * poll_ms;
  localparam int unsigned poll_w      = (poll_cycles > 1) ? $clog2(poll_cycles) : 1;
  localparam int unsigned wd_w        = $clog2(timeout_cycles + 1);

  typedef enum logic [2:0] {
    INIT_ISSUE, INIT_WAIT, IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [wd_w-1:0]   wd_cnt_q;
  logic [poll_w-1:0] poll_cnt_q;
  logic              poll_pend_q, set_pend_q;
  logic [55:0]       set_hold_q, set_act_q;
  logic [7:0]        shadow [7];

  logic       poll_tick, wd_expired, is_issue, is_wait;
  logic       start_wr, start_rd, rd_capture, publish, wr_finish, timeout;
  logic [7:0] issue_addr, issue_data, wr_byte;
  logic [2:0] wr_sel;

  assign poll_tick  = (poll_cnt_q == poll_w'(poll_cycles - 1));
  assign wd_expired = (wd_cnt_q == wd_w'(timeout_cycles));
  assign is_issue   = (state_q == INIT_ISSUE) || (state_q == RD_ISSUE) || (state_q == WR_ISSUE);
  assign is_wait    = (state_q == INIT_WAIT) || (state_q == RD_WAIT) || (state_q == WR_WAIT);
  assign busy       = (state_q != IDLE);

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    start_wr   = 1'b0;
    start_rd   = 1'b0;
    rd_capture = 1'b0;
    publish    = 1'b0;
    wr_finish  = 1'b0;
    timeout    = 1'b0;
    case (state_q)
      INIT_ISSUE: state_d = INIT_WAIT;
      INIT_WAIT: begin
        if (rw_write_done) begin
          state_d = IDLE;
        end else if (wd_expired) begin
          timeout = 1'b1;
          state_d = INIT_ISSUE;
        end
      end
      IDLE: begin
        if (set_pend_q) begin
          start_wr = 1'b1;
          idx_d    = 3'd0;
          state_d  = WR_ISSUE;
        end else if (poll_pend_q) begin
          start_rd = 1'b1;
          idx_d    = 3'd0;
          state_d  = RD_ISSUE;
        end
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT: begin
        if (rw_read_done) begin
          rd_capture = 1'b1;
          if (idx_q == 3'd6) begin
            publish = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = RD_ISSUE;
          end
        end else if (wd_expired) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      WR_ISSUE: state_d = WR_WAIT;
      WR_WAIT: begin
        if (rw_write_done) begin
          if (idx_q == 3'd7) begin
            wr_finish = 1'b1;
            state_d   = IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = WR_ISSUE;
          end
        end else if (wd_expired) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = INIT_ISSUE;
    endcase
  end

  // Write step 0 clears write-protect; steps 1..7 walk 0x80..0x8C with CH forced low on sec.
  always_comb begin
    issue_addr = 8'h8E;
    issue_data = 8'h00;
    wr_sel     = idx_q - 3'd1;
    wr_byte    = set_act_q[{wr_sel, 3'b000} +: 8];
    case (state_q)
      RD_ISSUE: issue_addr = 8'h80 + {4'd0, idx_q, 1'b0};
      WR_ISSUE: begin
        if (idx_q != 3'd0) begin
          issue_addr = 8'h80 + {4'd0, wr_sel, 1'b0};
          issue_data = (wr_sel == 3'd0) ? {1'b0, wr_byte[6:0]} : wr_byte;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q          <= INIT_ISSUE;
      idx_q            <= '0;
      wd_cnt_q         <= '0;
      poll_cnt_q       <= '0;
      poll_pend_q      <= 1'b0;
      set_pend_q       <= 1'b0;
      set_hold_q       <= '0;
      set_act_q        <= '0;
      rw_addr          <= 8'h8E;
      rw_wdata         <= 8'h00;
      rw_write_trigger <= 1'b0;
      rw_read_trigger  <= 1'b0;
      sec              <= 8'h00;
      min              <= 8'h00;
      hour             <= 8'h00;
      date             <= 8'h00;
      month            <= 8'h00;
      week             <= 8'h00;
      year             <= 8'h00;
      time_valid       <= 1'b0;
      set_done         <= 1'b0;
      err              <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      poll_cnt_q <= poll_tick ? '0 : poll_cnt_q + poll_w'(1);

      // Pend flags drop when their sequence starts; a new request or a timeout re-arms them.
      if (poll_tick)                           poll_pend_q <= 1'b1;
      else if (start_rd)                       poll_pend_q <= 1'b0;
      else if (timeout && state_q == RD_WAIT)  poll_pend_q <= 1'b1;

      if (set_trigger)                         set_pend_q <= 1'b1;
      else if (start_wr)                       set_pend_q <= 1'b0;
      else if (timeout && state_q == WR_WAIT)  set_pend_q <= 1'b1;

      if (set_trigger)
        set_hold_q <= {set_year, set_week, set_month, set_date, set_hour, set_min, set_sec};
      if (start_wr)
        set_act_q <= set_hold_q;

      rw_write_trigger <= (state_q == INIT_ISSUE) || (state_q == WR_ISSUE);
      rw_read_trigger  <= (state_q == RD_ISSUE);
      if (is_issue) begin
        rw_addr  <= issue_addr;
        rw_wdata <= issue_data;
        wd_cnt_q <= '0;
      end else if (is_wait && !wd_expired) begin
        wd_cnt_q <= wd_cnt_q + wd_w'(1);
      end

      if (publish) begin
        sec   <= shadow[0];
        min   <= shadow[1];
        hour  <= shadow[2];
        date  <= shadow[3];
        month <= shadow[4];
        week  <= shadow[5];
        year  <= rw_read_byte;
      end
      time_valid <= publish;
      set_done   <= wr_finish;
      err        <= timeout;
    end
  end

  // NOTE: the shadow is not reset; each entry is rewritten before a complete sequence can publish it.
  always_ff @(posedge sclk) begin
    if (rd_capture)
      shadow[idx_q] <= rw_read_byte;
  end

endmodule

// File: tb/tb_ds1302_rtc_ctrl.sv
// Directed bench for ds1302_rtc_ctrl with a behavioural byte-engine model.
module tb_ds1302_rtc_ctrl;

  logic       sclk = 1'b0;
  logic       rst  = 1'b1;
  logic       set_trigger = 1'b0;
  logic [7:0] set_sec = 8'h00, set_min = 8'h00, set_hour = 8'h00, set_date = 8'h00;
  logic [7:0] set_month = 8'h00, set_week = 8'h00, set_year = 8'h00;
  logic [7:0] sec, min, hour, date, month, week, year;
  logic       time_valid, set_done, err, busy;
  logic [7:0] rw_addr, rw_wdata;
  logic       rw_write_trigger, rw_read_trigger;
  logic [7:0] rw_read_byte = 8'h00;
  logic       rw_write_done = 1'b0, rw_read_done = 1'b0;

  ds1302_rtc_ctrl #(
    .sys_clk_freq  (1000),
    .poll_ms       (300),
    .timeout_cycles(80)
  ) dut (
    .sclk            (sclk),
    .rst             (rst),
    .set_trigger     (set_trigger),
    .set_sec         (set_sec),
    .set_min         (set_min),
    .set_hour        (set_hour),
    .set_date        (set_date),
    .set_month       (set_month),
    .set_week        (set_week),
    .set_year        (set_year),
    .sec             (sec),
    .min             (min),
    .hour            (hour),
    .date            (date),
    .month           (month),
    .week            (week),
    .year            (year),
    .time_valid      (time_valid),
    .set_done        (set_done),
    .err             (err),
    .busy            (busy),
    .rw_addr         (rw_addr),
    .rw_wdata        (rw_wdata),
    .rw_write_trigger(rw_write_trigger),
    .rw_read_trigger (rw_read_trigger),
    .rw_read_byte    (rw_read_byte),
    .rw_write_done   (rw_write_done),
    .rw_read_done    (rw_read_done)
  );

  always #5 sclk = ~sclk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Engine model: done arrives lat cycles after the trigger is seen; one read can be dropped.
  logic [7:0] rd_regs [7];
  int   lat = 10;
  bit   drop_arm = 1'b0;
  int   drop_cnt = 0;
  int   cnt = 0;
  bit   pend_w = 1'b0, pend_r = 1'b0;
  logic [7:0] pend_byte = 8'h00;
  int   k_sel;

  always @(posedge sclk) begin
    rw_write_done <= 1'b0;
    rw_read_done  <= 1'b0;
    k_sel = (int'(rw_addr) - 'h80) / 2;
    if (rst) begin
      cnt <= 0;
    end else if (rw_write_trigger) begin
      cnt    <= lat;
      pend_w <= 1'b1;
      pend_r <= 1'b0;
    end else if (rw_read_trigger) begin
      pend_byte <= (k_sel >= 0 && k_sel < 7) ? rd_regs[k_sel] : 8'hEE;
      pend_w    <= 1'b0;
      pend_r    <= 1'b1;
      if (drop_arm && drop_cnt == 2) begin
        cnt      <= 0;
        drop_arm <= 1'b0;
      end else begin
        cnt <= lat;
      end
      if (drop_arm) drop_cnt <= drop_cnt + 1;
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        rw_write_done <= pend_w;
        rw_read_done  <= pend_r;
        rw_read_byte  <= pend_byte;
      end
    end
  end

  // Transaction and pulse monitor.
  logic [15:0] wr_log [$];
  logic [7:0]  rd_log [$];
  int tv_cnt = 0, sd_cnt = 0, err_cnt = 0;

  always @(negedge sclk) begin
    if (rw_write_trigger) wr_log.push_back({rw_addr, rw_wdata});
    if (rw_read_trigger)  rd_log.push_back(rw_addr);
    if (time_valid) tv_cnt++;
    if (set_done)   sd_cnt++;
    if (err)        err_cnt++;
  end

  localparam int W_WDONE = 0, W_TV = 1, W_SD = 2, W_RTRIG = 3, W_ERR = 4, W_WR86 = 5, W_IDLE = 6;

  function automatic bit sig(input int which);
    case (which)
      W_WDONE: return rw_write_done;
      W_TV:    return time_valid;
      W_SD:    return set_done;
      W_RTRIG: return rw_read_trigger;
      W_ERR:   return err;
      W_WR86:  return rw_write_trigger && (rw_addr == 8'h86);
      W_IDLE:  return !busy;
      default: return 1'b0;
    endcase
  endfunction

  task automatic step();
    @(negedge sclk);
    #1;
  endtask

  task automatic wait_for(input int which, input int budget, input string tag);
    int n = 0;
    while (!sig(which) && n < budget) begin
      step();
      n++;
    end
    check({tag, "_seen"}, 64'(sig(which)), 64'd1);
  endtask

  task automatic load_set(input logic [7:0] s, mi, h, d, mo, w, y);
    set_sec = s; set_min = mi; set_hour = h; set_date = d;
    set_month = mo; set_week = w; set_year = y;
    set_trigger = 1'b1;
    step();
    set_trigger = 1'b0;
  endtask

  task automatic check_time(input string tag, input logic [55:0] exp);
    check(tag, {year, week, month, date, hour, min, sec}, exp);
  endtask

  logic [15:0] exp_set1 [8];
  int rd_mark, wr_mark, tv_base, sd_base, err_base;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    rd_regs = '{8'h45, 8'h30, 8'h12, 8'h07, 8'h08, 8'h04, 8'h25};
    exp_set1 = '{16'h8E00, 16'h8059, 16'h8258, 16'h8423, 16'h8631, 16'h8812, 16'h8A07, 16'h8C99};

    // Reset state
    repeat (3) step();
    check_time("rst_time", 56'h0);
    check("rst_pulses", {time_valid, set_done, err}, 3'b000);
    check("rst_busy", busy, 1'b1);
    check("rst_addr", rw_addr, 8'h8E);
    check("rst_wdata", rw_wdata, 8'h00);
    check("rst_trig", {rw_write_trigger, rw_read_trigger}, 2'b00);

    // Init: write-protect clear issued on the cycle after release
    rst = 1'b0;
    step();
    check("init_trig", {rw_write_trigger, rw_read_trigger, rw_addr, rw_wdata}, {2'b10, 8'h8E, 8'h00});
    wait_for(W_WDONE, 40, "init_done");
    check("init_busy_at_done", busy, 1'b1);
    step();
    check("init_busy_after", busy, 1'b0);

    // Poll
    rd_mark = rd_log.size();
    wait_for(W_TV, 800, "poll1");
    check_time("poll1_time", 56'h25_04_08_07_12_30_45);
    check("poll1_nreads", rd_log.size() - rd_mark, 7);
    for (int k = 0; k < 7; k++)
      check($sformatf("poll1_addr%0d", k), rd_log[rd_mark + k], 8'h80 + 8'(2 * k));
    step();
    check("poll1_tv_pulse", time_valid, 1'b0);
    check("poll1_tv_cnt", tv_cnt, 1);

    // Set with CH bit raised on the seconds input
    wr_mark = wr_log.size();
    rd_mark = rd_log.size();
    load_set(8'hD9, 8'h58, 8'h23, 8'h31, 8'h12, 8'h07, 8'h99);
    wait_for(W_SD, 400, "set1");
    check("set1_nwrites", wr_log.size() - wr_mark, 8);
    for (int k = 0; k < 8; k++)
      check($sformatf("set1_wr%0d", k), wr_log[wr_mark + k], exp_set1[k]);
    step();
    check("set1_sd_pulse", set_done, 1'b0);
    check("set1_sd_cnt", sd_cnt, 1);
    check("set1_no_read", rd_log.size() - rd_mark, 0);
    check_time("set1_time_kept", 56'h25_04_08_07_12_30_45);

    // Collision: set and a poll tick both land inside a slow read
    lat = 50;
    rd_regs = '{8'h11, 8'h22, 8'h03, 8'h14, 8'h05, 8'h06, 8'h21};
    wait_for(W_RTRIG, 400, "coll_read_start");
    tv_base = tv_cnt;
    sd_base = sd_cnt;
    load_set(8'h10, 8'h20, 8'h08, 8'h15, 8'h06, 8'h03, 8'h24);
    wr_mark = wr_log.size();
    wait_for(W_TV, 1500, "coll_read");
    lat = 10;
    check_time("coll_time", 56'h21_06_05_14_03_22_11);
    check("coll_no_set_yet", sd_cnt, sd_base);
    step();
    wait_for(W_SD, 600, "coll_set");
    check("coll_set_nwrites", wr_log.size() - wr_mark, 8);
    check("coll_set_sec", wr_log[wr_mark + 1], 16'h8010);
    check("coll_set_year", wr_log[wr_mark + 7], 16'h8C24);
    check("coll_no_read_between", tv_cnt, tv_base + 1);
    step();
    wait_for(W_TV, 120, "coll_reread");
    check("coll_sd_total", sd_cnt, sd_base + 1);
    check("coll_tv_total", tv_cnt, tv_base + 2);
    step();

    // Timeout on the third read, then a clean retry
    rd_regs = '{8'h33, 8'h44, 8'h15, 8'h16, 8'h09, 8'h02, 8'h26};
    drop_cnt = 0;
    drop_arm = 1'b1;
    err_base = err_cnt;
    tv_base = tv_cnt;
    wait_for(W_ERR, 600, "tmo_err");
    check_time("tmo_time_kept", 56'h21_06_05_14_03_22_11);
    step();
    check("tmo_err_pulse", err, 1'b0);
    check("tmo_no_publish", tv_cnt, tv_base);
    wait_for(W_TV, 200, "tmo_retry");
    check_time("tmo_retry_time", 56'h26_02_09_16_15_44_33);
    check("tmo_err_cnt", err_cnt, err_base + 1);
    step();

    // Reset in the middle of a write sequence
    sd_base = sd_cnt;
    load_set(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07);
    wait_for(W_WR86, 200, "mid_wr_idx4");
    rst = 1'b1;
    step();
    step();
    check_time("midrst_time", 56'h0);
    check("midrst_busy", busy, 1'b1);
    check("midrst_addr_data", {rw_addr, rw_wdata}, 16'h8E00);
    check("midrst_trig", {rw_write_trigger, rw_read_trigger}, 2'b00);
    rst = 1'b0;
    step();
    check("midrst_init_trig", {rw_write_trigger, rw_addr, rw_wdata}, {1'b1, 8'h8E, 8'h00});
    wait_for(W_IDLE, 60, "midrst_idle");
    repeat (30) step();
    check("midrst_stays_idle", busy, 1'b0);
    check("midrst_no_set_done", sd_cnt, sd_base);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
